// File: rtl/alu_cmd_master.sv
// Command master for a combinational ALU: accepts a command, holds the ALU inputs for SETTLE cycles,
// captures the result and offers it as a response. Optional overflow counter: define ALU_CMD_OVFCNT_EN.
module alu_cmd_master #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [1:0]         cmd_func,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_func,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_ovf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_ovf,
  output logic               busy
`ifdef ALU_CMD_OVFCNT_EN
  ,
  output logic [7:0]         ovf_count
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  localparam logic [1:0] FUNC_DIV = 2'b11;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [1:0]           alu_func_q, alu_func_d;
  logic [2*WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                 rsp_ovf_q, rsp_ovf_d;
`ifdef ALU_CMD_OVFCNT_EN
  logic [7:0]           ovf_count_q, ovf_count_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
`ifdef ALU_CMD_OVFCNT_EN
    ovf_count_d = ovf_count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d    = cmd_a;
          alu_b_d    = cmd_b;
          alu_func_d = cmd_func;
          // Divide-by-zero never waits on the ALU; its response is fixed.
          if (cmd_func == FUNC_DIV && cmd_b == '0) begin
            rsp_data_d = '1;
            rsp_ovf_d  = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = alu_out;
          rsp_ovf_d  = alu_ovf;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
`ifdef ALU_CMD_OVFCNT_EN
          if (rsp_ovf_q && ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
`ifdef ALU_CMD_OVFCNT_EN
      ovf_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
`ifdef ALU_CMD_OVFCNT_EN
      ovf_count_q <= ovf_count_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
`ifdef ALU_CMD_OVFCNT_EN
  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench for alu_cmd_master: directed and random commands against an arithmetic reference model,
// with a separate monitor that checks every presented response.
module tb_alu_cmd_master;
  localparam int W      = 6;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [W-1:0]   cmd_a, cmd_b;
  logic [1:0]     cmd_func;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_func;
  logic [2*W-1:0] alu_out;
  logic           alu_ovf;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic           rsp_ovf;
  logic           busy;
`ifdef ALU_CMD_OVFCNT_EN
  logic [7:0]     ovf_count;
`endif

  alu_cmd_master #(.WIDTH(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .busy(busy)
`ifdef ALU_CMD_OVFCNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU stand-in: add/sub flag carry/borrow, mul is full width, div is {quotient, remainder}.
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_func)
      2'b00: {alu_ovf, alu_out[W-1:0]} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        alu_out[W-1:0] = alu_a - alu_b;
        alu_ovf        = (alu_a < alu_b);
      end
      2'b10: alu_out = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
      default: begin
        if (alu_b == '0) begin
          alu_out = '1;
          alu_ovf = 1'b1;
        end else begin
          alu_out = {alu_a / alu_b, alu_a % alu_b};
        end
      end
    endcase
  end

  typedef struct {
    int unsigned d;
    bit          o;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   ready_mode = 0;
  bit   seen  = 1'b0;
  int   ovf_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int f, input int a, input int b);
    exp_t e;
    int   m = 1 << W;
    e.lat = SETTLE;
    e.o   = 1'b0;
    case (f)
      0: begin e.d = (a + b) % m; e.o = (a + b) >= m; end
      1: begin e.d = (a - b + m) % m; e.o = a < b; end
      2: e.d = a * b;
      default: begin
        if (b == 0) begin
          e.d   = m * m - 1;
          e.o   = 1'b1;
          e.lat = 0;
        end else begin
          e.d = (a / b) * m + (a % b);
        end
      end
    endcase
    e.acc = 0;
    return e;
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: inputs only change just after rising edges, so everything is stable here.
  always begin
    @(negedge clk);
    if (!rst) begin
`ifdef ALU_CMD_OVFCNT_EN
      chk("ovf_count", ovf_count, ovf_model);
`endif
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("spurious_rsp_valid", 1, 0);
        end else begin
          if (!seen) begin
            chk("rsp_latency", cyc - q[0].acc, q[0].lat);
            seen = 1'b1;
          end
          chk("rsp_data", rsp_data, q[0].d);
          chk("rsp_ovf", rsp_ovf, q[0].o);
          chk("busy_in_resp", busy, 1);
          if (rsp_ready) begin
            if (q[0].o && ovf_model < 255) ovf_model++;
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input int f, input int a, input int b);
    exp_t e;
    int   n = 0;
    cmd_valid = 1'b1;
    cmd_a     = W'(a);
    cmd_b     = W'(b);
    cmd_func  = 2'(f);
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e     = model(f, a, b);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("alu_a_loaded", alu_a, a);
    chk("alu_b_loaded", alu_b, b);
    chk("alu_func_loaded", alu_func, f);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_func  = '0;
    rsp_ready = 1'b0;
    #3;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_ovf", rsp_ovf, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_func", alu_func, 0);
    #19 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_busy", busy, 0);

    // Directed operations
    send(0, 20, 30);
    send(0, 40, 30);
    send(2, 63, 63);
    send(3, 45, 7);
    send(3, 9, 0);
    send(1, 3, 10);
    drain();

    // Consumer stalls while a new command waits at the input
    @(negedge clk);
    ready_mode = 2;
    @(posedge clk);
    #1;
    send(1, 50, 17);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk("stall_rsp_timeout", rsp_valid, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_a     = W'(33);
    cmd_b     = W'(5);
    cmd_func  = 2'b10;
    repeat (5) begin
      @(negedge clk);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_alu_a", alu_a, 50);
      chk("stall_alu_b", alu_b, 17);
      chk("stall_alu_func", alu_func, 1);
    end
    ready_mode = 0;
    @(negedge clk);
    chk("handshake_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("after_handshake_cmd_ready", cmd_ready, 1);
    chk("after_handshake_rsp_valid", rsp_valid, 0);
    e     = model(2, 33, 5);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("new_cmd_alu_a", alu_a, 33);
    chk("new_cmd_alu_b", alu_b, 5);
    chk("new_cmd_alu_func", alu_func, 2);
    drain();

    // Asynchronous reset in the middle of WAIT
    send(0, 60, 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_alu_a", alu_a, 0);
    chk("async_rst_alu_b", alu_b, 0);
    chk("async_rst_alu_func", alu_func, 0);
    chk("async_rst_rsp_data", rsp_data, 0);
    chk("async_rst_rsp_ovf", rsp_ovf, 0);
    q.delete();
    seen      = 1'b0;
    ovf_model = 0;
    #1 rst = 1'b0;
    repeat (SETTLE + 3) begin
      @(negedge clk);
      chk("discarded_no_rsp", rsp_valid, 0);
      chk("discarded_cmd_ready", cmd_ready, 1);
    end
    @(posedge clk);
    #1;
    send(0, 7, 8);
    drain();

    // Random traffic with a randomly stalling consumer
    @(negedge clk);
    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      int f = int'($urandom_range(0, 3));
      int a = int'($urandom_range(0, (1 << W) - 1));
      int b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      send(f, a, b);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    ready_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
